// File: rtl/phy_tx_arbiter_pkg.sv
// Shared definitions for the PHY TX arbiter slice.
//   tx_state_e        : link bring-up state encoding (IDLE, TRAIN, ACTIVE)
//   IDLE_WORD_DEFAULT : training / idle-fill symbol word
//   DATA_W            : width of requester and PHY data words
package phy_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } tx_state_e;

  localparam int          DATA_W            = 32;
  localparam logic [31:0] IDLE_WORD_DEFAULT = 32'hBCBC_BCBC;

endpackage

// File: rtl/phy_tx_rr_arb2.sv
// Combinational two-way round-robin grant.
//   enable      : in  - arbitration allowed this cycle (all grants low otherwise)
//   valid0/1    : in  - requester offers a word
//   last_served : in  - 1 when requester 1 was served most recently
//   grant0/1    : out - one-hot (or zero) grant
// A lone valid requester always wins; on a tie the requester not served
// last wins.
module phy_tx_rr_arb2 (
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  input  logic last_served,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (enable) begin
      if (valid0 && (!valid1 || last_served)) begin
        grant0 = 1'b1;
      end else if (valid1) begin
        grant1 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// PHY TX arbiter: brings the link up with a run of training words, then
// multiplexes two requester streams onto the PHY TX data path.
//   clk_2f_c              : in  - single clock, rising edge
//   reset                 : in  - synchronous, active-high
//   en                    : in  - link enable; dropping it returns to IDLE
//   req0_valid/req0_data  : in  - requester 0 word offer
//   req1_valid/req1_data  : in  - requester 1 word offer
//   req0_ready/req1_ready : out - combinational grants (transfer on valid && ready)
//   valid_in_phy          : out - registered PHY TX valid_in
//   Data_in_phy           : out - registered PHY TX Data_in
//   link_up               : out - registered, high only in ACTIVE
//   tx_count              : out - registered count of accepted words (wraps)
// Build option: define PHY_TX_IDLE_INSERT_EN to emit IDLE_WORD with valid
// on every ACTIVE cycle that follows a cycle without an accepted word.
module phy_tx_arbiter
  import phy_tx_arbiter_pkg::*;
#(
  parameter int          TRAIN_WORDS = 4,
  parameter logic [31:0] IDLE_WORD   = IDLE_WORD_DEFAULT
) (
  input  logic              clk_2f_c,
  input  logic              reset,
  input  logic              en,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              valid_in_phy,
  output logic [DATA_W-1:0] Data_in_phy,
  output logic              link_up,
  output logic [15:0]       tx_count
);

`ifdef PHY_TX_IDLE_INSERT_EN
  localparam logic FILL_VALID = 1'b1;
`else
  localparam logic FILL_VALID = 1'b0;
`endif

  // Training counter holds the number of TRAIN cycles still to come.
  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);

  tx_state_e         state_q;
  logic              last_served_q;
  logic [7:0]        train_cnt_q;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              link_q;
  logic [15:0]       tx_count_q;

  logic              arb_en;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] accept_data;

  // Grants are suppressed by reset and by en low in the same cycle.
  assign arb_en = !reset && en && (state_q == ACTIVE);

  phy_tx_rr_arb2 u_arb (
    .enable      (arb_en),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_served (last_served_q),
    .grant0      (grant0),
    .grant1      (grant1)
  );

  assign accept      = grant0 || grant1;
  assign accept_data = grant0 ? req0_data : req1_data;

  // ---- stage p0 -> p1: state update and registered PHY outputs ----
  always_ff @(posedge clk_2f_c) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      train_cnt_q   <= 8'd0;
      vld_p1        <= 1'b0;
      data_p1       <= '0;
      link_q        <= 1'b0;
      tx_count_q    <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q     <= TRAIN;
            train_cnt_q <= TRAIN_LAST;
            vld_p1      <= 1'b1;
            data_p1     <= IDLE_WORD;
          end else begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
          end
        end
        TRAIN: begin
          if (!en) begin
            state_q     <= IDLE;
            train_cnt_q <= 8'd0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
          end else if (train_cnt_q == 8'd0) begin
            state_q <= ACTIVE;
            link_q  <= 1'b1;
            vld_p1  <= FILL_VALID;
            data_p1 <= IDLE_WORD;
          end else begin
            train_cnt_q <= train_cnt_q - 8'd1;
            vld_p1      <= 1'b1;
            data_p1     <= IDLE_WORD;
          end
        end
        ACTIVE: begin
          if (!en) begin
            state_q <= IDLE;
            link_q  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
          end else if (accept) begin
            vld_p1        <= 1'b1;
            data_p1       <= accept_data;
            last_served_q <= grant1;
            tx_count_q    <= tx_count_q + 16'd1;
          end else begin
            // Without idle insertion the data bus keeps its last word.
            vld_p1 <= FILL_VALID;
            if (FILL_VALID) begin
              data_p1 <= IDLE_WORD;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          link_q  <= 1'b0;
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end
      endcase
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign valid_in_phy = vld_p1;
  assign Data_in_phy  = data_p1;
  assign link_up      = link_q;
  assign tx_count     = tx_count_q;

endmodule
